// File: rtl/spi_mbox_pkg.sv
// Shared types and constants for the SPI-side AXI4-Lite mailbox.
package spi_mbox_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;

  // Register offsets within the 32-byte window (addr[4:0]).
  localparam logic [4:0] MBOX_TX_DATA = 5'h00;
  localparam logic [4:0] MBOX_RX_DATA = 5'h04;
  localparam logic [4:0] MBOX_STATUS  = 5'h08;
  localparam logic [4:0] MBOX_CTRL    = 5'h0C;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // STATUS register layout.
  localparam int unsigned ST_TX_FULL      = 0;
  localparam int unsigned ST_TX_EMPTY     = 1;
  localparam int unsigned ST_RX_FULL      = 2;
  localparam int unsigned ST_RX_EMPTY     = 3;
  localparam int unsigned ST_TX_COUNT_LSB = 8;
  localparam int unsigned ST_RX_COUNT_LSB = 16;

  // CTRL register layout.
  localparam int unsigned CTRL_IRQ_EN = 0;
  localparam int unsigned CTRL_CLEAR  = 1;

  typedef enum logic {W_IDLE, W_RESP} wfsm_e;
  typedef enum logic {R_IDLE, R_RESP} rfsm_e;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [2:0]            prot;
  } axi_lite_ax_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0]   data;
    logic [AXI_DATA_W/8-1:0] strb;
  } axi_lite_w_t;

  typedef struct packed {
    logic [1:0] resp;
  } axi_lite_b_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
  } axi_lite_r_t;

  typedef struct packed {
    axi_lite_ax_t aw;
    axi_lite_w_t  w;
    axi_lite_ax_t ar;
    logic         aw_valid;
    logic         w_valid;
    logic         ar_valid;
    logic         b_ready;
    logic         r_ready;
  } axi_lite_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    logic        ar_ready;
    axi_lite_b_t b;
    logic        b_valid;
    axi_lite_r_t r;
    logic        r_valid;
  } axi_lite_rsp_t;

endpackage

// File: rtl/spi_mbox_fifo.sv
// Synchronous FIFO with registered head output and flush. A push while full
// is dropped even if a pop happens in the same cycle.
module spi_mbox_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Storage, pointers and occupancy; flush wins over any push or pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/spi_axi_lite_mailbox.sv
// AXI4-Lite slave mailbox between the SPI bridge and on-chip logic:
// host writes fill TX, chip pushes fill RX, with status/control and an
// RX-pending interrupt. Read and write channels run independently.
module spi_axi_lite_mailbox
  import spi_mbox_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  axi_lite_req_t axi_lite_req_i,
  output axi_lite_rsp_t axi_lite_rsp_o,
  output logic [31:0]   tx_data_o,
  output logic          tx_valid_o,
  input  logic          tx_ready_i,
  input  logic [31:0]   rx_data_i,
  input  logic          rx_valid_i,
  output logic          rx_ready_o,
  output logic          irq_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  // FIFO interconnect
  logic          tx_push, tx_full, tx_empty;
  logic          rx_pop, rx_full, rx_empty;
  logic [CW-1:0] tx_count, rx_count;
  logic [31:0]   rx_head;
  logic          ctrl_clear;

  // Write channel state
  wfsm_e       wstate_q;
  logic        aw_held_q, w_held_q;
  logic [31:0] awaddr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        b_valid_q;
  logic [1:0]  bresp_q, bresp_d;
  logic        irq_en_q, irq_en_d;

  // Read channel state
  rfsm_e       rstate_q;
  logic        r_valid_q;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  logic        aw_fire, w_fire, wr_commit, ar_fire;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;
  logic [4:0]  wr_off, rd_off;
  logic [31:0] status_word;

  spi_mbox_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (ctrl_clear),
    .push_i  (tx_push),
    .data_i  (wr_data),
    .pop_i   (tx_ready_i),
    .data_o  (tx_data_o),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  spi_mbox_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (ctrl_clear),
    .push_i  (rx_valid_i),
    .data_i  (rx_data_i),
    .pop_i   (rx_pop),
    .data_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  assign tx_valid_o = ~tx_empty;
  assign rx_ready_o = ~rx_full;
  assign irq_o      = irq_en_q & ~rx_empty;

  // aw and w may each arrive first; use the held copy if present, else the bus.
  assign aw_fire   = axi_lite_req_i.aw_valid & ~aw_held_q;
  assign w_fire    = axi_lite_req_i.w_valid & ~w_held_q;
  assign wr_addr   = aw_held_q ? awaddr_q : axi_lite_req_i.aw.addr;
  assign wr_data   = w_held_q ? wdata_q : axi_lite_req_i.w.data;
  assign wr_strb   = w_held_q ? wstrb_q : axi_lite_req_i.w.strb;
  assign wr_commit = (wstate_q == W_IDLE) & (aw_held_q | aw_fire) & (w_held_q | w_fire);
  assign wr_off    = {wr_addr[4:2], 2'b00};

  assign ar_fire   = (rstate_q == R_IDLE) & axi_lite_req_i.ar_valid;
  assign rd_off    = {axi_lite_req_i.ar.addr[4:2], 2'b00};

  // STATUS snapshot taken from current FIFO state, before any pop this cycle.
  always_comb begin
    status_word = '0;
    status_word[ST_TX_FULL]  = tx_full;
    status_word[ST_TX_EMPTY] = tx_empty;
    status_word[ST_RX_FULL]  = rx_full;
    status_word[ST_RX_EMPTY] = rx_empty;
    status_word[ST_TX_COUNT_LSB +: 8] = 8'(tx_count);
    status_word[ST_RX_COUNT_LSB +: 8] = 8'(rx_count);
  end

  // Write-side register effects, evaluated on the commit cycle only.
  always_comb begin
    tx_push    = 1'b0;
    ctrl_clear = 1'b0;
    irq_en_d   = irq_en_q;
    bresp_d    = RESP_OKAY;
    if (wr_commit) begin
      if (wr_addr[4]) begin
        bresp_d = RESP_DECERR;
      end else begin
        case (wr_off)
          MBOX_TX_DATA: begin
            if (tx_full) bresp_d = RESP_SLVERR;
            else         tx_push = 1'b1;
          end
          MBOX_CTRL: begin
            if (wr_strb[0]) irq_en_d = wr_data[CTRL_IRQ_EN];
            ctrl_clear = wr_data[CTRL_CLEAR];
          end
          default: bresp_d = RESP_OKAY;
        endcase
      end
    end
  end

  // Write FSM: latch aw/w independently, respond once both are held.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wstate_q  <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      b_valid_q <= 1'b0;
      bresp_q   <= RESP_OKAY;
      irq_en_q  <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      case (wstate_q)
        W_IDLE: begin
          if (aw_fire) begin
            aw_held_q <= 1'b1;
            awaddr_q  <= axi_lite_req_i.aw.addr;
          end
          if (w_fire) begin
            w_held_q <= 1'b1;
            wdata_q  <= axi_lite_req_i.w.data;
            wstrb_q  <= axi_lite_req_i.w.strb;
          end
          if (wr_commit) begin
            wstate_q  <= W_RESP;
            b_valid_q <= 1'b1;
            bresp_q   <= bresp_d;
          end
        end
        W_RESP: begin
          if (axi_lite_req_i.b_ready) begin
            wstate_q  <= W_IDLE;
            b_valid_q <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // Read data/response selection and the RX pop on ar accept.
  always_comb begin
    rdata_d = '0;
    rresp_d = RESP_OKAY;
    rx_pop  = 1'b0;
    if (axi_lite_req_i.ar.addr[4]) begin
      rresp_d = RESP_DECERR;
    end else begin
      case (rd_off)
        MBOX_RX_DATA: begin
          if (rx_empty) begin
            rresp_d = RESP_SLVERR;
          end else begin
            rdata_d = rx_head;
            rx_pop  = ar_fire;
          end
        end
        MBOX_STATUS: rdata_d = status_word;
        MBOX_CTRL:   rdata_d[CTRL_IRQ_EN] = irq_en_q;
        default:     rdata_d = '0;
      endcase
    end
  end

  // Read FSM: register the response on ar accept, hold until r_ready.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rstate_q  <= R_IDLE;
      r_valid_q <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (ar_fire) begin
            rstate_q  <= R_RESP;
            r_valid_q <= 1'b1;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
          end
        end
        R_RESP: begin
          if (axi_lite_req_i.r_ready) begin
            rstate_q  <= R_IDLE;
            r_valid_q <= 1'b0;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  // Response channel assembly from registered state.
  always_comb begin
    axi_lite_rsp_o          = '0;
    axi_lite_rsp_o.aw_ready = ~aw_held_q;
    axi_lite_rsp_o.w_ready  = ~w_held_q;
    axi_lite_rsp_o.ar_ready = (rstate_q == R_IDLE);
    axi_lite_rsp_o.b.resp   = bresp_q;
    axi_lite_rsp_o.b_valid  = b_valid_q;
    axi_lite_rsp_o.r.data   = rdata_q;
    axi_lite_rsp_o.r.resp   = rresp_q;
    axi_lite_rsp_o.r_valid  = r_valid_q;
  end

  // Address bits outside the decode window and prot are intentionally unused.
  logic unused_ok;
  assign unused_ok = ^{wr_addr[31:5], wr_addr[1:0], wr_strb[3:1], wr_data[31:2],
                       axi_lite_req_i.aw.prot, axi_lite_req_i.ar.prot,
                       axi_lite_req_i.ar.addr[31:5], axi_lite_req_i.ar.addr[1:0]};

endmodule

// File: tb/tb_spi_axi_lite_mailbox.sv
// Directed self-checking bench for the SPI AXI4-Lite mailbox.
module tb_spi_axi_lite_mailbox;
  import spi_mbox_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  axi_lite_req_t req;
  axi_lite_rsp_t rsp;
  logic [31:0]   tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [31:0]   rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          irq;

  int n_cmp = 0;
  int n_err = 0;

  spi_axi_lite_mailbox #(.FIFO_DEPTH(8)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .axi_lite_req_i (req),
    .axi_lite_rsp_o (rsp),
    .tx_data_o      (tx_data),
    .tx_valid_o     (tx_valid),
    .tx_ready_i     (tx_ready),
    .rx_data_i      (rx_data),
    .rx_valid_i     (rx_valid),
    .rx_ready_o     (rx_ready),
    .irq_o          (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // aw and w presented together; checks b_valid one cycle after accept.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] exp_resp, input string tag);
    int n;
    @(negedge clk);
    req.aw.addr = a; req.w.data = d; req.w.strb = s;
    req.aw_valid = 1'b1; req.w_valid = 1'b1; req.b_ready = 1'b0;
    n = 0;
    while (!(rsp.aw_ready && rsp.w_ready) && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_awwready"}, 32'(rsp.aw_ready & rsp.w_ready), 32'd1);
    @(negedge clk);
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    chk({tag, "_bvalid"}, 32'(rsp.b_valid), 32'd1);
    chk({tag, "_bresp"}, 32'(rsp.b.resp), 32'(exp_resp));
    req.b_ready = 1'b1;
    @(negedge clk);
    req.b_ready = 1'b0;
  endtask

  // Single read; checks r_valid one cycle after accept plus data/resp.
  task automatic axi_read(input logic [31:0] a, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input string tag);
    int n;
    @(negedge clk);
    req.ar.addr = a; req.ar_valid = 1'b1; req.r_ready = 1'b0;
    n = 0;
    while (!rsp.ar_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_arready"}, 32'(rsp.ar_ready), 32'd1);
    @(negedge clk);
    req.ar_valid = 1'b0;
    chk({tag, "_rvalid"}, 32'(rsp.r_valid), 32'd1);
    chk({tag, "_rdata"}, rsp.r.data, exp_data);
    chk({tag, "_rresp"}, 32'(rsp.r.resp), 32'(exp_resp));
    req.r_ready = 1'b1;
    @(negedge clk);
    req.r_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req = '0; req.w.strb = 4'hF;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    rst_n = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_aw_ready", 32'(rsp.aw_ready), 32'd1);
    chk("rst_w_ready",  32'(rsp.w_ready),  32'd1);
    chk("rst_ar_ready", 32'(rsp.ar_ready), 32'd1);
    chk("rst_b_valid",  32'(rsp.b_valid),  32'd0);
    chk("rst_r_valid",  32'(rsp.r_valid),  32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data",  tx_data, 32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_irq",      32'(irq), 32'd0);
    axi_read(32'h08, 32'h0000_000A, RESP_OKAY, "rst_status");

    // Single TX write, then drain
    axi_write(32'h00, 32'hDEAD_BEEF, 4'hF, RESP_OKAY, "tx1");
    chk("tx1_valid", 32'(tx_valid), 32'd1);
    chk("tx1_data",  tx_data, 32'hDEAD_BEEF);
    axi_read(32'h00, 32'd0, RESP_OKAY, "txdata_rd");
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    chk("tx1_drained", 32'(tx_valid), 32'd0);

    // Overfill TX: 8 OKAY then SLVERR; wstrb ignored for TX_DATA
    for (int i = 0; i < 8; i++)
      axi_write(32'h00, 32'h100 + i, 4'h0, RESP_OKAY, "txfill");
    axi_write(32'h00, 32'h1FF, 4'hF, RESP_SLVERR, "txover");
    axi_read(32'h08, 32'h0000_0809, RESP_OKAY, "txfull_status");
    @(negedge clk);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", 32'(tx_valid), 32'd1);
      chk("drain_data",  tx_data, 32'h100 + i);
      @(negedge clk);
    end
    tx_ready = 1'b0;
    chk("drain_empty", 32'(tx_valid), 32'd0);

    // RX push with irq enabled, read back, then underflow read
    axi_write(32'h0C, 32'h1, 4'hF, RESP_OKAY, "ctrl_en");
    chk("irq_idle", 32'(irq), 32'd0);
    rx_data = 32'h1234; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("irq_pending", 32'(irq), 32'd1);
    axi_read(32'h04, 32'h1234, RESP_OKAY, "rx_pop");
    chk("irq_cleared", 32'(irq), 32'd0);
    axi_read(32'h04, 32'd0, RESP_SLVERR, "rx_empty_rd");
    axi_read(32'h0C, 32'h1, RESP_OKAY, "ctrl_rd");

    // Decode errors and ignored writes
    axi_read(32'h14, 32'd0, RESP_DECERR, "dec_rd");
    axi_write(32'h18, 32'hFFFF_FFFF, 4'hF, RESP_DECERR, "dec_wr");
    axi_write(32'h08, 32'hFFFF_FFFF, 4'hF, RESP_OKAY, "status_wr");
    axi_read(32'h0C, 32'h1, RESP_OKAY, "ctrl_after_dec");

    // w first, aw 3 cycles later (upper address bits ignored), b_ready held low
    @(negedge clk);
    req.w.data = 32'h1; req.w.strb = 4'hF; req.w_valid = 1'b1; req.b_ready = 1'b0;
    @(negedge clk);
    req.w_valid = 1'b0;
    chk("split_w_ready",  32'(rsp.w_ready),  32'd0);
    chk("split_aw_ready", 32'(rsp.aw_ready), 32'd1);
    chk("split_b_early",  32'(rsp.b_valid),  32'd0);
    repeat (2) @(negedge clk);
    chk("split_b_wait", 32'(rsp.b_valid), 32'd0);
    req.aw.addr = 32'h20C; req.aw_valid = 1'b1;
    @(negedge clk);
    req.aw_valid = 1'b0;
    chk("split_b_valid", 32'(rsp.b_valid), 32'd1);
    chk("split_b_resp",  32'(rsp.b.resp), 32'(RESP_OKAY));
    repeat (3) @(negedge clk);
    chk("bhold_aw_ready", 32'(rsp.aw_ready), 32'd0);
    chk("bhold_b_valid",  32'(rsp.b_valid),  32'd1);
    req.b_ready = 1'b1;
    @(negedge clk);
    req.b_ready = 1'b0;
    chk("bdone_aw_ready", 32'(rsp.aw_ready), 32'd1);
    chk("bdone_b_valid",  32'(rsp.b_valid),  32'd0);

    // RX full: pop and push request in the same cycle, no push-through
    @(negedge clk);
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 32'hA0 + i;
      @(negedge clk);
    end
    rx_data = 32'hFF;
    chk("rxfull_ready", 32'(rx_ready), 32'd0);
    req.ar.addr = 32'h04; req.ar_valid = 1'b1; req.r_ready = 1'b0;
    @(negedge clk);
    rx_valid = 1'b0; req.ar_valid = 1'b0;
    chk("rxfull_rvalid", 32'(rsp.r_valid), 32'd1);
    chk("rxfull_rdata",  rsp.r.data, 32'hA0);
    chk("rxfull_rresp",  32'(rsp.r.resp), 32'(RESP_OKAY));
    chk("rxfull_ready7", 32'(rx_ready), 32'd1);
    req.r_ready = 1'b1;
    @(negedge clk);
    req.r_ready = 1'b0;
    axi_read(32'h08, 32'h0007_0002, RESP_OKAY, "rx7_status");
    axi_read(32'h04, 32'hA1, RESP_OKAY, "rx7_head");
    chk("rx6_irq", 32'(irq), 32'd1);

    // Clear with data in both FIFOs
    axi_write(32'h00, 32'h55, 4'hF, RESP_OKAY, "pre_clr_tx");
    chk("pre_clr_txv", 32'(tx_valid), 32'd1);
    axi_write(32'h0C, 32'h3, 4'hF, RESP_OKAY, "clear");
    chk("clr_tx_valid", 32'(tx_valid), 32'd0);
    chk("clr_rx_ready", 32'(rx_ready), 32'd1);
    chk("clr_irq",      32'(irq), 32'd0);
    axi_read(32'h08, 32'h0000_000A, RESP_OKAY, "clr_status");
    axi_read(32'h0C, 32'h1, RESP_OKAY, "clr_ctrl");

    // Reset during an outstanding write
    rx_data = 32'h99; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("prerst_irq", 32'(irq), 32'd1);
    req.aw.addr = 32'h00; req.w.data = 32'h77; req.aw_valid = 1'b1; req.w_valid = 1'b1;
    req.b_ready = 1'b0;
    @(negedge clk);
    chk("prerst_b_valid", 32'(rsp.b_valid), 32'd1);
    chk("prerst_tx_valid", 32'(tx_valid), 32'd1);
    #1 rst_n = 1'b0;
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    #1;
    chk("mrst_b_valid",  32'(rsp.b_valid),  32'd0);
    chk("mrst_aw_ready", 32'(rsp.aw_ready), 32'd1);
    chk("mrst_w_ready",  32'(rsp.w_ready),  32'd1);
    chk("mrst_ar_ready", 32'(rsp.ar_ready), 32'd1);
    chk("mrst_r_valid",  32'(rsp.r_valid),  32'd0);
    chk("mrst_tx_valid", 32'(tx_valid), 32'd0);
    chk("mrst_tx_data",  tx_data, 32'd0);
    chk("mrst_rx_ready", 32'(rx_ready), 32'd1);
    chk("mrst_irq",      32'(irq), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req.b_ready = 1'b1;
    repeat (2) @(negedge clk);
    req.b_ready = 1'b0;
    chk("post_rst_b_valid", 32'(rsp.b_valid), 32'd0);
    axi_read(32'h0C, 32'h0, RESP_OKAY, "post_rst_ctrl");
    axi_read(32'h08, 32'h0000_000A, RESP_OKAY, "post_rst_status");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
